// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch with one outstanding request, stall skid buffer,
// flush redirect with stale-response drop, and HLT detection.
`default_nettype none

module if_fetch_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IF_Flush,
  input  logic [15:0] br_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic [15:0] PC,
  output logic [15:0] IF_ID_Inst,
  output logic [15:0] IF_ID_PCplus2,
  output logic        IF_ID_valid,
  output logic        halted
);

  localparam logic [15:0] BUBBLE_INST = 16'hA000;
  localparam logic [3:0]  OP_HLT      = 4'b1111;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DROP   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] skid_data;
  logic        skid_valid;

  logic        outstanding;
  logic        word_avail;
  logic [15:0] word;
  logic [15:0] pc_plus2;

  // A captured skid word means memory has already answered, so no request is live.
  // In DROP the memory still owes the abandoned response.
  assign imem_req    = (state == RUN) && !skid_valid;
  assign imem_addr   = PC;
  assign outstanding = imem_req || (state == DROP);
  assign word_avail  = (state == RUN) && (skid_valid || imem_valid);
  assign word        = skid_valid ? skid_data : imem_data;
  assign pc_plus2    = PC + 16'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      PC            <= 16'h0000;
      IF_ID_Inst    <= BUBBLE_INST;
      IF_ID_PCplus2 <= 16'h0000;
      IF_ID_valid   <= 1'b0;
      skid_data     <= 16'h0000;
      skid_valid    <= 1'b0;
      halted        <= 1'b0;
    end else if (IF_Flush) begin
      IF_ID_Inst    <= BUBBLE_INST;
      IF_ID_PCplus2 <= 16'h0000;
      IF_ID_valid   <= 1'b0;
      PC            <= br_target;
      skid_valid    <= 1'b0;
      halted        <= 1'b0;
      state         <= (outstanding && !imem_valid) ? DROP : RUN;
    end else if (stall) begin
      if (state == RUN && imem_valid) begin
        skid_data  <= imem_data;
        skid_valid <= 1'b1;
      end
      if (state == DROP && imem_valid) begin
        state <= RUN;
      end
    end else begin
      case (state)
        RUN: begin
          if (word_avail) begin
            IF_ID_Inst    <= word;
            IF_ID_PCplus2 <= pc_plus2;
            IF_ID_valid   <= 1'b1;
            skid_valid    <= 1'b0;
            if (word[15:12] == OP_HLT) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              PC <= pc_plus2;
            end
          end else begin
            IF_ID_Inst    <= BUBBLE_INST;
            IF_ID_PCplus2 <= 16'h0000;
            IF_ID_valid   <= 1'b0;
          end
        end
        DROP: begin
          IF_ID_Inst    <= BUBBLE_INST;
          IF_ID_PCplus2 <= 16'h0000;
          IF_ID_valid   <= 1'b0;
          if (imem_valid) begin
            state <= RUN;
          end
        end
        HALTED: begin
          // Fetch is stopped; the HLT word stays visible in IF/ID.
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scenarios plus randomized stall/flush/latency run
// checked against an instruction-stream model of the fetch stage.
`default_nettype none

module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        IF_Flush;
  logic [15:0] br_target;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [15:0] PC;
  logic [15:0] IF_ID_Inst;
  logic [15:0] IF_ID_PCplus2;
  logic        IF_ID_valid;
  logic        halted;

  int n_chk  = 0;
  int n_pass = 0;

  // Memory model state
  logic [15:0] mem_ovr [int];
  int          m_lat;
  bit          m_busy;
  int          m_rem;
  logic [15:0] m_addr;

  if_fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IF_Flush     (IF_Flush),
    .br_target    (br_target),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .imem_valid   (imem_valid),
    .PC           (PC),
    .IF_ID_Inst   (IF_ID_Inst),
    .IF_ID_PCplus2(IF_ID_PCplus2),
    .IF_ID_valid  (IF_ID_valid),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
    return {1'b0, a[14:0] ^ 15'h2B5D};
  endfunction

  // One clock: DUT samples at the edge; memory answers a request after m_lat cycles.
  task automatic step();
    logic        req_k;
    logic        vld_k;
    logic [15:0] addr_k;
    req_k  = imem_req;
    addr_k = imem_addr;
    vld_k  = imem_valid;
    @(posedge clk);
    #1;
    imem_data = 16'($urandom);
    if (!rst_n) begin
      m_busy     = 1'b0;
      imem_valid = 1'b0;
    end else begin
      if (vld_k) begin
        m_busy = 1'b0;
      end else if (!m_busy && req_k) begin
        m_busy = 1'b1;
        m_rem  = m_lat;
        m_addr = addr_k;
      end
      imem_valid = 1'b0;
      if (m_busy && !vld_k) begin
        m_rem = m_rem - 1;
        if (m_rem <= 0) begin
          imem_valid = 1'b1;
          imem_data  = mem_word(m_addr);
        end
      end
    end
  endtask

  task automatic wait_load(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (IF_ID_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_chk++;
    if ({PC, IF_ID_Inst, IF_ID_PCplus2, IF_ID_valid, halted} !== {16'h0, 16'hA000, 16'h0, 1'b0, 1'b0})
      $display("FAIL reset_state: got PC=%h inst=%h p2=%h v=%b h=%b, expected PC=0000 inst=a000 p2=0000 v=0 h=0",
               PC, IF_ID_Inst, IF_ID_PCplus2, IF_ID_valid, halted);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_chk++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000})
      $display("FAIL reset_first_req: got req=%b addr=%h, expected req=1 addr=0000", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_basic();
    step(); step();
    n_chk++;
    if ({IF_ID_Inst, IF_ID_PCplus2, IF_ID_valid, PC} !== {16'h1123, 16'h0002, 1'b1, 16'h0002})
      $display("FAIL basic_word0: got inst=%h p2=%h v=%b PC=%h, expected 1123 0002 1 0002",
               IF_ID_Inst, IF_ID_PCplus2, IF_ID_valid, PC);
    else n_pass++;
    step(); step();
    n_chk++;
    if ({IF_ID_Inst, IF_ID_PCplus2, IF_ID_valid, PC} !== {16'h2456, 16'h0004, 1'b1, 16'h0004})
      $display("FAIL basic_word1: got inst=%h p2=%h v=%b PC=%h, expected 2456 0004 1 0004",
               IF_ID_Inst, IF_ID_PCplus2, IF_ID_valid, PC);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [15:0] w4;
    w4 = mem_word(16'h0004);
    step(); step();
    n_chk++;
    if (PC !== 16'h0006) $display("FAIL stall_setup_pc: got %h expected 0006", PC);
    else n_pass++;
    stall = 1'b1;
    step(); step();
    n_chk++;
    if ({imem_req, PC, IF_ID_Inst, IF_ID_PCplus2, IF_ID_valid} !== {1'b0, 16'h0006, w4, 16'h0006, 1'b1})
      $display("FAIL stall_capture: got req=%b PC=%h inst=%h p2=%h v=%b, expected 0 0006 %h 0006 1",
               imem_req, PC, IF_ID_Inst, IF_ID_PCplus2, IF_ID_valid, w4);
    else n_pass++;
    step();
    n_chk++;
    if ({imem_req, PC, IF_ID_Inst, IF_ID_PCplus2} !== {1'b0, 16'h0006, w4, 16'h0006})
      $display("FAIL stall_hold: got req=%b PC=%h inst=%h p2=%h, expected 0 0006 %h 0006",
               imem_req, PC, IF_ID_Inst, IF_ID_PCplus2, w4);
    else n_pass++;
    stall = 1'b0;
    step();
    n_chk++;
    if ({IF_ID_Inst, IF_ID_PCplus2, IF_ID_valid, PC} !== {16'h8312, 16'h0008, 1'b1, 16'h0008})
      $display("FAIL stall_release: got inst=%h p2=%h v=%b PC=%h, expected 8312 0008 1 0008",
               IF_ID_Inst, IF_ID_PCplus2, IF_ID_valid, PC);
    else n_pass++;
    n_chk++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0008})
      $display("FAIL stall_next_req: got req=%b addr=%h, expected 1 0008", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_flush_drop();
    bit ok;
    m_lat = 3;
    IF_Flush = 1'b1; br_target = 16'h0010;
    step();
    IF_Flush = 1'b0;
    wait_req(ok);
    n_chk++;
    if (!ok || imem_addr !== 16'h0010)
      $display("FAIL drop_setup: got ok=%b addr=%h, expected 1 0010", ok, imem_addr);
    else n_pass++;
    step();
    IF_Flush = 1'b1; br_target = 16'h0040;
    step();
    IF_Flush = 1'b0;
    n_chk++;
    if ({IF_ID_Inst, IF_ID_PCplus2, IF_ID_valid, PC, imem_req} !== {16'hA000, 16'h0, 1'b0, 16'h0040, 1'b0})
      $display("FAIL drop_flush: got inst=%h p2=%h v=%b PC=%h req=%b, expected a000 0000 0 0040 0",
               IF_ID_Inst, IF_ID_PCplus2, IF_ID_valid, PC, imem_req);
    else n_pass++;
    wait_req(ok);
    n_chk++;
    if (!ok || {imem_addr, IF_ID_valid} !== {16'h0040, 1'b0})
      $display("FAIL drop_discard: got ok=%b addr=%h v=%b, expected 1 0040 0", ok, imem_addr, IF_ID_valid);
    else n_pass++;
    wait_load(ok);
    n_chk++;
    if (!ok || {IF_ID_Inst, IF_ID_PCplus2, PC} !== {mem_word(16'h0040), 16'h0042, 16'h0042})
      $display("FAIL drop_resume: got ok=%b inst=%h p2=%h PC=%h, expected 1 %h 0042 0042",
               ok, IF_ID_Inst, IF_ID_PCplus2, PC, mem_word(16'h0040));
    else n_pass++;
  endtask

  task automatic test_flush_stall();
    bit ok;
    m_lat = 1;
    step();
    IF_Flush = 1'b1; stall = 1'b1; br_target = 16'h0080;
    step();
    IF_Flush = 1'b0; stall = 1'b0;
    n_chk++;
    if ({IF_ID_Inst, IF_ID_valid, PC, imem_req, imem_addr} !== {16'hA000, 1'b0, 16'h0080, 1'b1, 16'h0080})
      $display("FAIL flush_stall: got inst=%h v=%b PC=%h req=%b addr=%h, expected a000 0 0080 1 0080",
               IF_ID_Inst, IF_ID_valid, PC, imem_req, imem_addr);
    else n_pass++;
    wait_load(ok);
    n_chk++;
    if (!ok || {IF_ID_Inst, IF_ID_PCplus2} !== {mem_word(16'h0080), 16'h0082})
      $display("FAIL flush_stall_skid: got ok=%b inst=%h p2=%h, expected 1 %h 0082",
               ok, IF_ID_Inst, IF_ID_PCplus2, mem_word(16'h0080));
    else n_pass++;
  endtask

  task automatic test_halt();
    bit ok;
    IF_Flush = 1'b1; br_target = 16'h0020;
    step();
    IF_Flush = 1'b0;
    wait_load(ok);
    n_chk++;
    if (!ok || {IF_ID_Inst, PC, halted} !== {16'hF000, 16'h0020, 1'b1})
      $display("FAIL halt_load: got ok=%b inst=%h PC=%h h=%b, expected 1 f000 0020 1", ok, IF_ID_Inst, PC, halted);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++;
      if ({imem_req, PC, halted} !== {1'b0, 16'h0020, 1'b1})
        $display("FAIL halt_hold: got req=%b PC=%h h=%b, expected 0 0020 1", imem_req, PC, halted);
      else n_pass++;
    end
    IF_Flush = 1'b1; br_target = 16'h0030;
    step();
    IF_Flush = 1'b0;
    n_chk++;
    if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0030})
      $display("FAIL halt_resume: got h=%b req=%b addr=%h, expected 0 1 0030", halted, imem_req, imem_addr);
    else n_pass++;
    wait_load(ok);
    n_chk++;
    if (!ok || IF_ID_Inst !== mem_word(16'h0030))
      $display("FAIL halt_resume_word: got ok=%b inst=%h, expected 1 %h", ok, IF_ID_Inst, mem_word(16'h0030));
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    IF_Flush = 1'b1; br_target = 16'hFFFE;
    step();
    IF_Flush = 1'b0;
    wait_load(ok);
    n_chk++;
    if (!ok || {IF_ID_Inst, IF_ID_PCplus2, PC} !== {16'h0000, 16'h0000, 16'h0000})
      $display("FAIL wrap: got ok=%b inst=%h p2=%h PC=%h, expected 1 0000 0000 0000", ok, IF_ID_Inst, IF_ID_PCplus2, PC);
    else n_pass++;
  endtask

  // Model: IF/ID delivers the memory image in address order from the latest
  // flush target; stalls freeze everything, flushes insert a bubble.
  task automatic test_random();
    logic [15:0] epc, ei, ep, tg;
    logic        ev;
    bit          fl, st;
    int          loads;
    loads = 0;
    epc = 16'h0; ei = 16'hA000; ep = 16'h0; ev = 1'b0;
    mem_ovr.delete();
    for (int i = 0; i < 400; i++) begin
      fl = (i == 0) || ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 9) < 3);
      tg = 16'($urandom) & 16'hFFFE;
      IF_Flush = fl; stall = st; br_target = tg;
      m_lat = $urandom_range(1, 4);
      step();
      if (fl) begin
        ei = 16'hA000; ep = 16'h0; ev = 1'b0; epc = tg;
      end else if (!st) begin
        if (IF_ID_valid) begin
          ei = mem_word(epc); ep = epc + 16'd2; ev = 1'b1; epc = epc + 16'd2; loads++;
        end else begin
          ei = 16'hA000; ep = 16'h0; ev = 1'b0;
        end
      end
      n_chk++;
      if ({IF_ID_Inst, IF_ID_PCplus2, IF_ID_valid, PC} !== {ei, ep, ev, epc})
        $display("FAIL rand_ifid cyc%0d: got inst=%h p2=%h v=%b PC=%h, expected %h %h %b %h",
                 i, IF_ID_Inst, IF_ID_PCplus2, IF_ID_valid, PC, ei, ep, ev, epc);
      else n_pass++;
      if (imem_req) begin
        n_chk++;
        if (imem_addr !== PC) $display("FAIL rand_addr cyc%0d: got %h expected %h", i, imem_addr, PC);
        else n_pass++;
      end
    end
    IF_Flush = 1'b0; stall = 1'b0;
    n_chk++;
    if (loads < 30) $display("FAIL rand_progress: got %0d loads, expected at least 30", loads);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; IF_Flush = 1'b0; stall = 1'b0; br_target = 16'h0;
    imem_data = 16'h0; imem_valid = 1'b0;
    m_lat = 1; m_busy = 1'b0; m_rem = 0; m_addr = 16'h0;
    mem_ovr[32'h0000] = 16'h1123;
    mem_ovr[32'h0002] = 16'h2456;
    mem_ovr[32'h0006] = 16'h8312;
    mem_ovr[32'h0010] = 16'h7777;
    mem_ovr[32'h0020] = 16'hF000;
    mem_ovr[32'hFFFE] = 16'h0000;
    #2;
    test_reset();
    test_basic();
    test_stall();
    test_flush_drop();
    test_flush_stall();
    test_halt();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL expose the following ports, with the clock and reset listed first:
  clk            in   1   single clock; all state updates on rising edge
  rst_n          in   1   asynchronous, active-low reset
  IF_Flush       in   1   redirect from hazard unit: squash IF/ID and load br_target
  br_target      in   16  resolved branch target PC
  stall          in   1   hold PC and IF/ID (load-use or branch-operand stall)
  imem_req       out  1   instruction fetch request
  imem_addr      out  16  fetch address
  imem_data      in   16  instruction word, valid with imem_valid
  imem_valid     in   1   one-cycle pulse: imem_data holds the word for the outstanding request
  PC             out  16  current fetch PC
  IF_ID_Inst     out  16  instruction to decode and hazard unit
  IF_ID_PCplus2  out  16  PC+2 of IF_ID_Inst
  IF_ID_valid    out  1   IF_ID_Inst is a real instruction
  halted         out  1   HLT (opcode 4'b1111) has been loaded into IF/ID; fetch stopped

Function
REQ-002 SHALL define the bubble as IF_ID_Inst=16'hA000, IF_ID_PCplus2=16'h0000, IF_ID_valid=0.
REQ-003 SHALL implement three states: RUN, DROP and HALTED.
REQ-004 In RUN, SHALL assert imem_req=1 with imem_addr=PC, and SHALL hold imem_addr stable until imem_valid or IF_Flush.
REQ-005 In DROP and HALTED, SHALL drive imem_req=0.
REQ-006 Per-cycle priority SHALL be: IF_Flush, then stall, then normal fetch.
REQ-007 When IF_Flush=1 in any state, the block SHALL, on the next edge:
  - load the bubble into IF/ID;
  - set PC=br_target;
  - clear the skid buffer.
REQ-008 The next state after IF_Flush SHALL be selected as follows:
  - DROP if a request is outstanding and imem_valid=0 this cycle;
  - otherwise RUN, discarding any imem_valid arriving in the same cycle;
  - HALTED on IF_Flush SHALL always go to RUN.
REQ-009 In DROP, the block SHALL discard the next imem_valid without writing IF/ID, then go to RUN and fetch from PC.
REQ-010 When stall=1 and IF_Flush=0, the block SHALL hold PC, IF_ID_Inst, IF_ID_PCplus2 and IF_ID_valid unchanged.
REQ-011 If imem_valid=1 during stall, the block SHALL capture imem_data into a 16-bit skid buffer (skid_valid=1) and SHALL drop imem_req.
REQ-012 When stall=0 and a word is available (skid_valid or imem_valid), the block SHALL:
  - load IF/ID with the word, PC+2 and valid=1;
  - set PC=PC+2, modulo 2^16 (0xFFFE -> 0x0000);
  - clear skid_valid.
REQ-013 When stall=0 and no word is available, the block SHALL load the bubble into IF/ID and hold PC.
REQ-014 When the loaded word has opcode 4'b1111, the block SHALL:
  - not advance PC (PC holds the HLT address);
  - transition to HALTED and assert halted=1 from the next edge.
REQ-015 The block SHALL issue at most one outstanding request; a new request SHALL start the cycle after a word is consumed.
REQ-016 Fetch latency SHALL be 1 cycle minimum: imem_valid in cycle n appears in IF/ID at edge n+1.

Reset
REQ-017 While rst_n=0, the block SHALL hold PC=16'h0000, IF/ID=bubble, skid_valid=0, state=RUN and halted=0.
REQ-018 After rst_n deasserts, imem_req SHALL equal 1 with imem_addr=16'h0000 in the first cycle.
REQ-019 Reset mid-request SHALL abandon the request; the memory shares rst_n.

Verification
REQ-020 Reset, then a 1-cycle-latency memory returning 16'h1123, 16'h2456 -> IF/ID holds 16'h1123 (PCplus2=2), then 16'h2456 (PCplus2=4); PC=4.
REQ-021 stall=1 for 3 cycles while imem_valid returns 16'h8312 at PC=6 -> IF/ID unchanged, imem_req=0 after capture; first stall=0 cycle loads 16'h8312 with PCplus2=8.
REQ-022 IF_Flush=1 with br_target=16'h0040 while a 3-cycle fetch of PC=0x10 is outstanding -> IF/ID=bubble, state DROP; the stale word is discarded; next request imem_addr=0x0040.
REQ-023 IF_Flush=1 and stall=1 with imem_valid in the same cycle -> flush wins: bubble, PC=br_target, skid empty, state RUN.
REQ-024 Fetch 16'hF000 at PC=0x0020 -> IF_ID_Inst=16'hF000, PC stays 0x0020, halted=1, imem_req=0 indefinitely; a following IF_Flush to 0x0030 resumes fetch at 0x0030 with halted=0.
REQ-025 PC=16'hFFFE fetch of 16'h0000 -> IF_ID_PCplus2=16'h0000, PC wraps to 16'h0000.
